// File: rtl/traceback_unit_if.sv
// Interface bundling the job handshake, memory read port and edit-op stream of traceback_unit.
// master is the traceback unit's view; slave is the DP stage / memory / op consumer side.
interface traceback_unit_if #(
    parameter int N                = 8,
    parameter int DIRECTION_WIDTH  = 2,
    parameter int MEM_AMOUNT_WIDTH = 4,
    parameter int ADDRESS_WIDTH    = 8,
    parameter int COL_WIDTH        = 3
);
    logic                          tb_valid;
    logic                          array_num;
    logic [MEM_AMOUNT_WIDTH-1:0]   end_block;
    logic [ADDRESS_WIDTH-1:0]      end_row;
    logic [COL_WIDTH-1:0]          end_col;
    logic [N*DIRECTION_WIDTH-1:0]  row_k0;
    logic [N*DIRECTION_WIDTH-1:0]  row_k1;
    logic                          tb_busy;
    logic [MEM_AMOUNT_WIDTH-1:0]   mem_block_num;
    logic [ADDRESS_WIDTH-1:0]      row_num;
    logic                          op_valid;
    logic [1:0]                    op;
    logic                          op_ready;
    logic                          done;
    logic                          done_array;

    modport master (
        input  tb_valid, array_num, end_block, end_row, end_col, row_k0, row_k1, op_ready,
        output tb_busy, mem_block_num, row_num, op_valid, op, done, done_array
    );

    modport slave (
        output tb_valid, array_num, end_block, end_row, end_col, row_k0, row_k1, op_ready,
        input  tb_busy, mem_block_num, row_num, op_valid, op, done, done_array
    );
endinterface

// File: rtl/traceback_unit.sv
// Walks a finished DP direction array backwards from an end cell and streams the
// alignment as edit operations, last operation first.
module traceback_unit #(
    parameter int N                = 8,
    parameter int DIRECTION_WIDTH  = 2,
    parameter int MEM_AMOUNT_WIDTH = 4,
    parameter int ADDRESS_WIDTH    = 8,
    parameter int COL_WIDTH        = 3
) (
    input  logic               clk,
    input  logic               reset_i,
    traceback_unit_if.master   bus
);
    localparam int DW = DIRECTION_WIDTH;
    localparam int RW = N * DIRECTION_WIDTH;

    localparam logic [DW-1:0] DIR_STOP = DW'(0);
    localparam logic [DW-1:0] DIR_DIAG = DW'(1);
    localparam logic [DW-1:0] DIR_UP   = DW'(2);
    localparam logic [DW-1:0] DIR_LEFT = DW'(3);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, EMIT, FIN} state_t;

    state_t                       state;
    state_t                       state_next;
    logic                         served;
    logic                         served_array;
    logic [MEM_AMOUNT_WIDTH-1:0]  cur_blk;
    logic [ADDRESS_WIDTH-1:0]     cur_row;
    logic [COL_WIDTH-1:0]         cur_col;
    logic [DW-1:0]                dir;
    logic [RW-1:0]                row0_buf;
    logic [RW-1:0]                row1_buf;
    logic                         k1_valid;
    logic [MEM_AMOUNT_WIDTH-1:0]  mem_block_reg;
    logic [ADDRESS_WIDTH-1:0]     row_num_reg;
    logic                         busy_reg;

    logic                         request;
    logic [DW-1:0]                wait_dir;
    logic [COL_WIDTH-1:0]         col_dec;
    logic [MEM_AMOUNT_WIDTH-1:0]  blk_dec;
    logic [DW-1:0]                left_next_dir;

    // A cell ends the walk when it is on row 0, is a stop code, or would step left of column 0.
    function automatic logic stops(input logic [ADDRESS_WIDTH-1:0] r,
                                   input logic [MEM_AMOUNT_WIDTH-1:0] b,
                                   input logic [COL_WIDTH-1:0] c,
                                   input logic [DW-1:0] d);
        return (r == '0) || (d == DIR_STOP) ||
               ((b == '0) && (c == '0) && ((d == DIR_DIAG) || (d == DIR_LEFT)));
    endfunction

    assign request       = bus.tb_valid & (~served | (bus.array_num != served_array));
    assign wait_dir      = bus.row_k0[cur_col*DW +: DW];
    assign col_dec       = (cur_col == '0) ? COL_WIDTH'(N - 1) : cur_col - 1'b1;
    assign blk_dec       = (cur_col == '0) ? cur_blk - 1'b1 : cur_blk;
    assign left_next_dir = (cur_col != '0) ? row0_buf[col_dec*DW +: DW]
                                           : row1_buf[(N-1)*DW +: DW];

    assign bus.tb_busy       = busy_reg;
    assign bus.mem_block_num = mem_block_reg;
    assign bus.row_num       = row_num_reg;

    always_comb begin
        state_next     = state;
        bus.op_valid   = 1'b0;
        bus.op         = 2'b00;
        bus.done       = 1'b0;
        bus.done_array = 1'b0;
        case (state)
            IDLE: if (request) state_next = ADDR;
            ADDR: state_next = WAIT;
            WAIT: state_next = stops(cur_row, cur_blk, cur_col, wait_dir) ? FIN : EMIT;
            EMIT: begin
                bus.op_valid = 1'b1;
                case (dir)
                    DIR_DIAG: bus.op = 2'b00;
                    DIR_UP:   bus.op = 2'b01;
                    default:  bus.op = 2'b10;
                endcase
                // A second block crossing has no valid neighbour row buffered, so it refetches.
                if (bus.op_ready) begin
                    if (dir != DIR_LEFT)
                        state_next = ADDR;
                    else if ((cur_col == '0) && !k1_valid)
                        state_next = ADDR;
                    else if (stops(cur_row, blk_dec, col_dec, left_next_dir))
                        state_next = FIN;
                    else
                        state_next = EMIT;
                end
            end
            FIN: begin
                bus.done       = 1'b1;
                bus.done_array = served_array;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address registers are loaded on the edge entering ADDR so memory sees them during ADDR.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state         <= IDLE;
            served        <= 1'b0;
            served_array  <= 1'b0;
            cur_blk       <= '0;
            cur_row       <= '0;
            cur_col       <= '0;
            dir           <= '0;
            row0_buf      <= '0;
            row1_buf      <= '0;
            k1_valid      <= 1'b0;
            mem_block_reg <= '0;
            row_num_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state    <= state_next;
            busy_reg <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (request) begin
                        served        <= 1'b1;
                        served_array  <= bus.array_num;
                        cur_blk       <= bus.end_block;
                        cur_row       <= bus.end_row;
                        cur_col       <= bus.end_col;
                        mem_block_reg <= bus.end_block;
                        row_num_reg   <= bus.end_row;
                    end
                end
                WAIT: begin
                    dir      <= wait_dir;
                    row0_buf <= bus.row_k0;
                    row1_buf <= bus.row_k1;
                    k1_valid <= 1'b1;
                end
                EMIT: begin
                    if (bus.op_ready) begin
                        case (dir)
                            DIR_DIAG: begin
                                cur_row       <= cur_row - 1'b1;
                                row_num_reg   <= cur_row - 1'b1;
                                cur_col       <= col_dec;
                                cur_blk       <= blk_dec;
                                mem_block_reg <= blk_dec;
                            end
                            DIR_UP: begin
                                cur_row     <= cur_row - 1'b1;
                                row_num_reg <= cur_row - 1'b1;
                            end
                            default: begin
                                cur_col <= col_dec;
                                cur_blk <= blk_dec;
                                if (cur_col != '0) begin
                                    dir <= left_next_dir;
                                end else if (k1_valid) begin
                                    dir      <= left_next_dir;
                                    row0_buf <= row1_buf;
                                    k1_valid <= 1'b0;
                                end else begin
                                    mem_block_reg <= blk_dec;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_unit.sv
// Directed testbench for traceback_unit: a memory responder, a cell-walking reference
// model with latency bookkeeping, and one compare thread checking every cycle.
module tb_traceback_unit;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_i;
    int   cyc = 0;

    traceback_unit_if bus();

    traceback_unit dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Direction memory indexed [block][row][column]; one-cycle registered read.
    logic [1:0]  mem [16][16][8];
    logic [15:0] rk0;
    logic [15:0] rk1;

    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            rk0[c*2 +: 2] <= mem[bus.mem_block_num][bus.row_num[3:0]][c];
            rk1[c*2 +: 2] <= mem[bus.mem_block_num - 4'd1][bus.row_num[3:0]][c];
        end
    end
    assign bus.row_k0 = rk0;
    assign bus.row_k1 = rk1;

    int vectors     = 0;
    int miscompares = 0;

    int exp_ops   [32];
    int exp_times [32];
    int exp_n;
    int exp_done_off;
    int exp_arr;
    int acc_cyc;
    int job_id    = 0;
    bit job_active = 0;
    bit timing_on  = 0;

    int ptr       = 0;
    int seen_job  = 0;
    bit cur_done  = 0;
    bit prev_done = 0;
    int done_cnt  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic clearMem();
        foreach (mem[b, r, c]) mem[b][r][c] = 2'b00;
    endtask

    // Reference walk over a linear column index; each diag/up costs 3 cycles, each left 1.
    task automatic buildExpected(input int blk, input int row, input int col);
        int g, r, t, d;
        g = blk * N + col;
        r = row;
        t = 3;
        exp_n = 0;
        while (r != 0 && exp_n < 32) begin
            d = int'(mem[g / N][r][g % N]);
            if (d == 0) break;
            if (g == 0 && (d == 1 || d == 3)) break;
            exp_ops[exp_n]   = (d == 1) ? 0 : (d == 2) ? 1 : 2;
            exp_times[exp_n] = t;
            exp_n++;
            if (d == 1) begin r--; g--; t += 3; end
            else if (d == 2) begin r--; t += 3; end
            else begin g--; t += 1; end
        end
        exp_done_off = t;
    endtask

    task automatic stepToEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int blk, input int row, input int col, input int arr, input bit timed);
        stepToEdge();
        buildExpected(blk, row, col);
        exp_arr       = arr;
        timing_on     = timed;
        acc_cyc       = cyc + 1;
        job_id++;
        job_active    = 1;
        bus.end_block = 4'(blk);
        bus.end_row   = 8'(row);
        bus.end_col   = 3'(col);
        bus.array_num = arr[0];
        bus.tb_valid  = 1'b1;
    endtask

    task automatic waitOffset(input int k);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while ((cyc - acc_cyc + 1) != k && g < 200);
        checkOutput("reach_offset", 32'(cyc - acc_cyc + 1), 32'(k));
    endtask

    task automatic waitDone(input int maxc);
        int start, g;
        start = done_cnt;
        g = 0;
        while (done_cnt == start && g < maxc) begin
            @(negedge clk);
            #1;
            g++;
        end
        checkOutput("done_seen", 32'(done_cnt - start), 32'd1);
        job_active = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},   32'(bus.tb_busy),       32'd0);
        checkOutput({tag, "_blk"},    32'(bus.mem_block_num), 32'd0);
        checkOutput({tag, "_row"},    32'(bus.row_num),       32'd0);
        checkOutput({tag, "_valid"},  32'(bus.op_valid),      32'd0);
        checkOutput({tag, "_op"},     32'(bus.op),            32'd0);
        checkOutput({tag, "_done"},   32'(bus.done),          32'd0);
        checkOutput({tag, "_darr"},   32'(bus.done_array),    32'd0);
    endtask

    task automatic compareCycle();
        int off;
        if (reset_i) begin
            prev_done = 0;
            return;
        end
        if (job_id != seen_job) begin
            seen_job = job_id;
            ptr      = 0;
            cur_done = 0;
        end
        off = cyc - acc_cyc + 1;
        if (prev_done) begin
            checkOutput("busy_after_done", 32'(bus.tb_busy), 32'd0);
            prev_done = 0;
        end
        if (job_active && off == 0) checkOutput("busy_before_accept", 32'(bus.tb_busy), 32'd0);
        if (job_active && off >= 1 && !cur_done) checkOutput("busy_in_job", 32'(bus.tb_busy), 32'd1);
        if (bus.op_valid) begin
            if (!job_active || ptr >= exp_n) begin
                checkOutput("op_valid_unexpected", 32'(bus.op_valid), 32'd0);
            end else begin
                checkOutput("op", 32'(bus.op), 32'(exp_ops[ptr]));
                if (bus.op_ready) begin
                    if (timing_on) checkOutput("op_time", 32'(off), 32'(exp_times[ptr]));
                    ptr++;
                end
            end
        end
        if (bus.done) begin
            if (!job_active || cur_done) begin
                checkOutput("done_unexpected", 32'(bus.done), 32'd0);
            end else begin
                checkOutput("done_array", 32'(bus.done_array), 32'(exp_arr));
                checkOutput("ops_remaining", 32'(exp_n - ptr), 32'd0);
                if (timing_on) checkOutput("done_time", 32'(off), 32'(exp_done_off));
                cur_done = 1;
                done_cnt++;
                prev_done = 1;
            end
        end
    endtask

    initial begin
        int start;
        reset_i       = 1'b1;
        bus.tb_valid  = 1'b0;
        bus.array_num = 1'b0;
        bus.end_block = '0;
        bus.end_row   = '0;
        bus.end_col   = '0;
        bus.op_ready  = 1'b1;
        clearMem();

        fork
            forever begin
                @(negedge clk);
                compareCycle();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        stepToEdge();
        reset_i = 1'b0;

        $display("[TB] pure diagonal");
        for (int r = 1; r <= 3; r++) for (int c = 0; c < N; c++) mem[0][r][c] = 2'b01;
        applyStimulus(0, 3, 3, 0, 1);
        checkOutput("model_diag_n", 32'(exp_n), 32'd3);
        checkOutput("model_diag_done", 32'(exp_done_off), 32'd12);
        waitDone(40);

        $display("[TB] left run across block boundary");
        clearMem();
        mem[1][2][1] = 2'b11;
        mem[1][2][0] = 2'b11;
        mem[0][2][7] = 2'b01;
        applyStimulus(1, 2, 1, 1, 1);
        checkOutput("model_left_ops", 32'(exp_ops[0] * 16 + exp_ops[1] * 4 + exp_ops[2]), 32'h28);
        checkOutput("model_left_done", 32'(exp_done_off), 32'd8);
        waitOffset(1);
        checkOutput("left_addr1_blk", 32'(bus.mem_block_num), 32'd1);
        checkOutput("left_addr1_row", 32'(bus.row_num), 32'd2);
        stepToEdge();
        bus.tb_valid = 1'b0;
        waitOffset(5);
        checkOutput("left_no_reread_blk", 32'(bus.mem_block_num), 32'd1);
        waitOffset(6);
        checkOutput("left_addr2_blk", 32'(bus.mem_block_num), 32'd0);
        checkOutput("left_addr2_row", 32'(bus.row_num), 32'd1);
        waitDone(40);

        $display("[TB] backpressure");
        clearMem();
        for (int r = 1; r <= 2; r++) for (int c = 0; c < N; c++) mem[0][r][c] = 2'b01;
        bus.op_ready = 1'b0;
        applyStimulus(0, 2, 2, 0, 0);
        waitOffset(3);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checkOutput("bp_valid", 32'(bus.op_valid), 32'd1);
            checkOutput("bp_blk", 32'(bus.mem_block_num), 32'd0);
            checkOutput("bp_row", 32'(bus.row_num), 32'd2);
        end
        stepToEdge();
        bus.op_ready = 1'b1;
        waitDone(40);

        $display("[TB] immediate stop");
        clearMem();
        applyStimulus(2, 5, 4, 1, 1);
        checkOutput("model_stop_n", 32'(exp_n), 32'd0);
        checkOutput("model_stop_done", 32'(exp_done_off), 32'd3);
        waitDone(20);

        $display("[TB] re-trigger rule");
        start = done_cnt;
        repeat (15) @(negedge clk);
        #1;
        checkOutput("retrigger_busy", 32'(bus.tb_busy), 32'd0);
        checkOutput("retrigger_jobs", 32'(done_cnt - start), 32'd0);
        mem[0][2][5] = 2'b10;
        mem[0][1][5] = 2'b11;
        applyStimulus(0, 2, 5, 0, 1);
        checkOutput("model_upleft_done", 32'(exp_done_off), 32'd7);
        waitDone(30);

        $display("[TB] reset during EMIT");
        clearMem();
        for (int r = 1; r <= 3; r++) for (int c = 0; c < N; c++) mem[0][r][c] = 2'b01;
        bus.op_ready = 1'b0;
        applyStimulus(0, 3, 3, 1, 0);
        waitOffset(3);
        checkOutput("pre_reset_valid", 32'(bus.op_valid), 32'd1);
        reset_i      = 1'b1;
        bus.tb_valid = 1'b0;
        job_active   = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkAllZero("midreset");
        stepToEdge();
        reset_i      = 1'b0;
        bus.op_ready = 1'b1;
        applyStimulus(0, 3, 3, 1, 1);
        waitDone(40);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
